f_mac_collect: RTL
==================

F_MAC_COLLECT -- requirements
Module: f_mac_collect

Interface
REQ-001 The parameters SHALL be: DATA_W, default 32, result word width.
REQ-002 The parameters SHALL be: LATENCY, default 30, cycles from issue to a valid MAC output; legal range 1 to 64.
REQ-003 The parameters SHALL be: DEPTH, default 4, result FIFO entries; power of two, at least 2.
REQ-004 The ports SHALL be: clk, input, 1, single clock, rising edge.
REQ-005 The ports SHALL be: rst, input, 1, reset; synchronous, active-high.
REQ-006 The ports SHALL be: issue_i, input, 1, one-cycle pulse marking that the final operand pair of a MAC accumulation enters the MAC this cycle.
REQ-007 The ports SHALL be: mac_i, input, DATA_W, MAC out0 result, sampled only at capture.
REQ-008 The ports SHALL be: issue_ready_o, output, 1, high when one more issue is guaranteed FIFO space.
REQ-009 The ports SHALL be: data_o, output, DATA_W, FIFO head word.
REQ-010 The ports SHALL be: valid_o, output, 1, FIFO non-empty.
REQ-011 The ports SHALL be: ready_i, input, 1, consumer accepts data_o.
REQ-012 The ports SHALL be: count_o, output, log2(DEPTH)+1, FIFO occupancy.
REQ-013 The ports SHALL be: overflow_o, output, 1, sticky flag for a dropped result.

Function
REQ-014 Each issue_i SHALL enter a LATENCY-bit tag shift register, and the tag SHALL emerge exactly LATENCY cycles later as capture.
REQ-015 Any number of issues SHALL be in flight at once, including back-to-back issues on consecutive cycles.
REQ-016 On capture, mac_i in that cycle SHALL be pushed to the FIFO tail.
REQ-017 A pop SHALL occur when valid_o and ready_i are both high.
REQ-018 data_o SHALL be the registered head word and SHALL be held stable while valid_o is high and ready_i is low.
REQ-019 The FIFO SHALL have no bypass: a push into an empty FIFO SHALL raise valid_o on the next cycle.
REQ-020 Push and pop in the same cycle SHALL leave count_o unchanged, including when the FIFO is full.
REQ-021 A capture while the FIFO is full with no pop in that cycle SHALL drop the word, leave the FIFO unchanged and set overflow_o.
REQ-022 overflow_o SHALL stay set until reset.
REQ-023 An in-flight counter SHALL increment on issue, decrement on capture, and stay unchanged when both occur in the same cycle.
REQ-024 issue_ready_o SHALL equal (in_flight + count_o) < DEPTH, computed combinationally from the registered counters.
REQ-025 An issue_i while issue_ready_o is low SHALL still be tracked and captured, and may cause an overflow.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 count_o SHALL range from 0 to DEPTH inclusive.

Reset
REQ-028 While rst is high, the tag register, in-flight counter, FIFO pointers and overflow_o SHALL clear on the clock edge.
REQ-029 After reset, valid_o = 0, count_o = 0, issue_ready_o = 1 and data_o = 0.
REQ-030 issue_i sampled while rst is high SHALL be ignored.
REQ-031 Issues in flight when reset is asserted SHALL be discarded and SHALL never produce a capture.

Configuration
REQ-032 When the macro F_MAC_COLLECT_RELU_EN is defined, a captured word with sign bit 1 SHALL be pushed as all-zero (+0).
REQ-033 With F_MAC_COLLECT_RELU_EN defined, NaN words (exponent all ones, nonzero fraction) SHALL pass unchanged.
REQ-034 When F_MAC_COLLECT_RELU_EN is undefined, captured words SHALL be pushed bit-exact.

Verification
REQ-035 The bench SHALL cover: LATENCY=30, issue at cycle 10, mac_i=0x40490FDB at cycle 40 -> valid_o rises at cycle 41 with data_o=0x40490FDB and count_o=1.
REQ-036 The bench SHALL cover: 4 back-to-back issues with ready_i=0 -> issue_ready_o goes low after the 4th; 4 words are stored in order; overflow_o stays 0.
REQ-037 The bench SHALL cover: 5 issues with ready_i=0, DEPTH=4 -> 5th capture is dropped, overflow_o=1, count_o=4, first 4 words read out in order.
REQ-038 The bench SHALL cover: FIFO full, capture and pop in the same cycle -> count_o stays 4 and the new word becomes the tail.
REQ-039 The bench SHALL cover: rst pulsed 15 cycles after an issue -> no capture ever appears, valid_o=0, issue_ready_o=1.
REQ-040 The bench SHALL cover: with F_MAC_COLLECT_RELU_EN defined, mac_i=0xC0000000 -> data_o=0x00000000, and mac_i=0xFFC00001 -> data_o=0xFFC00001.

Source files
------------

// File: rtl/f_mac_collect.sv
// f_mac_collect: tracks MAC accumulations in flight with a tag shift register and
// collects each finished result into a small FIFO. The result is sampled exactly
// LATENCY cycles after its final issue.
// Optional feature: define F_MAC_COLLECT_RELU_EN to push negative non-NaN results as +0.
module f_mac_collect #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 30,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_i,
    input  logic [DATA_W-1:0]       mac_i,
    output logic                    issue_ready_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IFL_W = $clog2(LATENCY + 1);
    localparam int unsigned SUM_W = ((IFL_W > CNT_W) ? IFL_W : CNT_W) + 1;

    logic [LATENCY-1:0] tag_q, tag_d;
    logic [IFL_W-1:0]   in_flight_q, in_flight_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               overflow_q, overflow_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];

    logic               capture_c;
    logic               pop_c;
    logic               push_c;
    logic               full_c;
    logic [DATA_W-1:0]  push_word_c;

    // The oldest tag position marks the cycle whose mac_i is the finished result.
    always_comb begin
        capture_c = tag_q[LATENCY-1];
    end

    // Tag shift register: one bit per cycle of MAC pipeline.
    generate
        if (LATENCY == 1) begin : g_tag_one
            always_comb begin
                tag_d = issue_i;
            end
        end else begin : g_tag_many
            always_comb begin
                tag_d = {tag_q[LATENCY-2:0], issue_i};
            end
        end
    endgenerate

`ifdef F_MAC_COLLECT_RELU_EN
    localparam int unsigned EXP_W  = (DATA_W >= 64) ? 11 : ((DATA_W >= 32) ? 8 : 5);
    localparam int unsigned FRAC_W = DATA_W - 1 - EXP_W;

    logic is_nan_c;

    // Clamp negative results to +0; NaNs keep their payload.
    always_comb begin
        is_nan_c    = (&mac_i[DATA_W-2 -: EXP_W]) && (|mac_i[FRAC_W-1:0]);
        push_word_c = (mac_i[DATA_W-1] && !is_nan_c) ? '0 : mac_i;
    end
`else
    // Results are stored bit-exact.
    always_comb begin
        push_word_c = mac_i;
    end
`endif

    // In-flight count mirrors the number of set bits in the tag register.
    always_comb begin
        in_flight_d = in_flight_q;
        if (issue_i && !capture_c) begin
            in_flight_d = in_flight_q + IFL_W'(1);
        end else if (capture_c && !issue_i) begin
            in_flight_d = in_flight_q - IFL_W'(1);
        end
    end

    // FIFO next state: a full FIFO still accepts a capture when the head leaves the same cycle.
    always_comb begin
        pop_c      = valid_q && ready_i;
        full_c     = (count_q == CNT_W'(DEPTH));
        push_c     = capture_c && (!full_c || pop_c);
        overflow_d = overflow_q | (capture_c && full_c && !pop_c);

        mem_d = mem_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = push_word_c;
        end

        wr_ptr_d = push_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_c  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        count_d = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end

        valid_d = (count_d != '0);

        // Registered head word; unchanged while the head stays put.
        data_d = data_q;
        if (count_d != '0) begin
            data_d = mem_d[rd_ptr_d];
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= '0;
            in_flight_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            in_flight_q <= in_flight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Admission check counts both queued words and results still in the MAC.
    always_comb begin
        issue_ready_o = (SUM_W'(in_flight_q) + SUM_W'(count_q)) < SUM_W'(DEPTH);
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule
